// File: rtl/types_pkg.sv
// Shared types for the pole/zero frame pipeline: per-beat flags and sequencer states.
package types_pkg;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pz_seq_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter. It steps one pixel per advance and wraps at the frame end.
module raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          advance,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_x,
    output logic          last_frame
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign last_x     = (x_q == XW'(H_RES - 1));
    assign last_frame = last_x && (y_q == YW'(V_RES - 1));
    assign x          = x_q;
    assign y          = y_q;

    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_frame ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pz_frame_sequencer.sv
// Frame sequencer: raster beats with valid/sof/eol, back-pressure handling, and
// per-frame shadowing of the pole/zero counts.
module pz_frame_sequencer
    import types_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int MAX_PZ = 8,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES),
    localparam int CW = $clog2(MAX_PZ) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          continuous,
    input  logic          stop,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_num_zeros,
    input  logic [CW-1:0] cfg_num_poles,
    input  logic          out_ready,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output flags_t        flags_out,
    output logic [CW-1:0] num_zeros,
    output logic [CW-1:0] num_poles,
    output logic          busy,
    output logic          frame_done
);

    pz_seq_state_t state_q, state_d;
    logic          stop_pending_q, stop_pending_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] pend_zeros_q, pend_zeros_d;
    logic [CW-1:0] pend_poles_q, pend_poles_d;
    logic [CW-1:0] num_zeros_q, num_zeros_d;
    logic [CW-1:0] num_poles_q, num_poles_d;

    logic          running, fire, last_beat, launch;
    logic          last_x, last_frame;
    logic [CW-1:0] zeros_clamped, poles_clamped;

    assign running   = (state_q == RUN);
    assign fire      = running && out_ready;
    assign last_beat = fire && last_frame;

    assign zeros_clamped = (cfg_num_zeros > CW'(MAX_PZ)) ? CW'(MAX_PZ) : cfg_num_zeros;
    assign poles_clamped = (cfg_num_poles > CW'(MAX_PZ)) ? CW'(MAX_PZ) : cfg_num_poles;

    // Held at zero while idle so every launch starts from (0,0).
    raster_counter #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_raster (
        .clk       (clk),
        .resetn    (resetn),
        .advance   (fire),
        .clear     (!running),
        .x         (x_out),
        .y         (y_out),
        .last_x    (last_x),
        .last_frame(last_frame)
    );

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        pend_zeros_d   = pend_zeros_q;
        pend_poles_d   = pend_poles_q;
        num_zeros_d    = num_zeros_q;
        num_poles_d    = num_poles_q;
        frame_done_d   = last_beat;
        launch         = 1'b0;

        if (cfg_valid) begin
            pend_zeros_d = zeros_clamped;
            pend_poles_d = poles_clamped;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = RUN;
                    launch         = 1'b1;
                    // A stop arriving with start bounds the run to this one frame.
                    stop_pending_d = stop;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pending_d = 1'b1;
                end
                if (last_beat) begin
                    if (!continuous || stop_pending_q) begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A config write coinciding with a launch bypasses the pending registers.
        if (launch) begin
            num_zeros_d = cfg_valid ? zeros_clamped : pend_zeros_q;
            num_poles_d = cfg_valid ? poles_clamped : pend_poles_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            stop_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            pend_zeros_q   <= '0;
            pend_poles_q   <= '0;
            num_zeros_q    <= '0;
            num_poles_q    <= '0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            frame_done_q   <= frame_done_d;
            pend_zeros_q   <= pend_zeros_d;
            pend_poles_q   <= pend_poles_d;
            num_zeros_q    <= num_zeros_d;
            num_poles_q    <= num_poles_d;
        end
    end

    // Flags decode only registered state, so no input reaches an output combinationally.
    assign flags_out.valid = running;
    assign flags_out.sof   = running && (x_out == '0) && (y_out == '0);
    assign flags_out.eol   = running && last_x;
    assign num_zeros       = num_zeros_q;
    assign num_poles       = num_poles_q;
    assign busy            = running;
    assign frame_done      = frame_done_q;

endmodule

// File: doc/pz_frame_sequencer.md
# pz_frame_sequencer

Frame-level controller that drives the pole/zero difference datapath. It generates the raster scan of pixel coordinates with `valid`/`sof`/`eol` flags, and honours the datapath's back-pressure. It also holds the active pole/zero counts in shadow registers so that configuration changes never tear a frame. It sits upstream of the per-pixel distance stage that feeds `pz_difference`.

## Interface
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame
- `MAX_PZ`, 8, maximum zeros (and maximum poles) per frame
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins frame generation when idle
- `continuous`  in  1  level; when 1, the next frame follows the current one back-to-back
- `stop`  in  1  pulse; finish the current frame, then go idle
- `cfg_valid`  in  1  pulse; capture `cfg_num_zeros`/`cfg_num_poles` into the pending registers
- `cfg_num_zeros`  in  `$clog2(MAX_PZ)+1`  requested zero count
- `cfg_num_poles`  in  `$clog2(MAX_PZ)+1`  requested pole count
- `out_ready`  in  1  downstream can accept a beat
- `x_out`  out  `$clog2(H_RES)`  pixel column
- `y_out`  out  `$clog2(V_RES)`  pixel row
- `flags_out`  out  `flags_t`  `{valid, sof, eol}` of the current beat
- `num_zeros`  out  `$clog2(MAX_PZ)+1`  active zero count, constant for the whole frame
- `num_poles`  out  `$clog2(MAX_PZ)+1`  active pole count, constant for the whole frame
- `busy`  out  1  high while not in IDLE
- `frame_done`  out  1  one-cycle pulse when the last beat of a frame is accepted

## Operation
- **States**
  - IDLE: `flags_out.valid`=0.
  - RUN: `flags_out.valid`=1 and a beat is presented.
  - IDLE→RUN on `start`.
  - RUN→IDLE when the last beat (x=`H_RES-1`, y=`V_RES-1`) is accepted while `continuous`=0 or `stop_pending`=1.
  - RUN→RUN on last-beat acceptance otherwise. There is no bubble; the next beat is (0,0) with `sof`=1.
- **Transfer.** A beat transfers on a cycle with `flags_out.valid`=1 and `out_ready`=1. While `out_ready`=0, all outputs hold.
- **Raster order.** `x` increments on each transfer. When x=`H_RES-1`, `x` wraps to 0 and `y` increments. When both wrap, the frame ends.
- **Flags.**
  - `sof`=1 only at (0,0).
  - `eol`=1 only at x=`H_RES-1`.
  - Both are 0 whenever `valid`=0.
- **Config.**
  - `cfg_valid` loads the pending registers. Each value is clamped to `MAX_PZ` if it exceeds `MAX_PZ`.
  - Pending values copy to `num_zeros`/`num_poles` on the cycle the (0,0) beat is launched: on IDLE→RUN, or on frame wrap.
  - If `cfg_valid` coincides with a launch, the new value applies to the frame being launched.
- **stop.**
  - In RUN, `stop` sets `stop_pending`. `stop_pending` clears on entry to IDLE.
  - In IDLE, `stop` alone is ignored.
  - `start` and `stop` together in IDLE produce exactly one frame.
- **start in RUN** is ignored.
- **frame_done** pulses the cycle after the last beat is accepted, in both the continuous and the stopping case.

## Timing
- **Reset** (asynchronous, on `resetn`=0): state IDLE; `x_out`, `y_out`, `flags_out`, `num_zeros`, `num_poles`, pending registers, `stop_pending`, `busy` and `frame_done` all 0.
- **Reset mid-frame** aborts immediately. No `frame_done` is produced.
- **Start latency:** with `start` sampled at edge N, the first beat (0,0,`sof`) is valid after edge N. `busy`=1 in the same cycle.
- **Throughput:** one beat per cycle while `out_ready`=1.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Idle return:** after the final accepted beat, `valid`=0 and `busy`=0 on the next cycle when stopping.

## Structure
- `flags_t` comes from `types_pkg`. Add the state enum `pz_seq_state_t` (IDLE, RUN) to `types_pkg`.
- Sub-module `raster_counter`, parameterised by `H_RES`/`V_RES`.
  - Inputs: `advance`, `clear`.
  - Outputs: `x`, `y`, `last_x`, `last_frame`.
- The top level holds the FSM, the config shadow/pending registers, and the flag generation.

## Test plan
All scenarios use `H_RES`=4, `V_RES`=3.
- **Single frame.** `start` with `continuous`=0 and `out_ready`=1 → 12 beats from (0,0) to (3,2); `sof` only on beat 0; `eol` on beats 3, 7, 11; `frame_done` one cycle later; then `busy`=0.
- **Back-pressure.** Drop `out_ready` for 5 cycles at (2,1) → outputs hold at (2,1); no coordinate skipped or repeated.
- **Continuous and stop.** `continuous`=1 → beat 12 is (0,0,`sof`) with no gap. `stop` at beat 15 → the frame completes at beat 23, then IDLE.
- **Config shadowing.**
  - `cfg_valid` (zeros=3, poles=5) mid-frame → `num_zeros`/`num_poles` unchanged until the next (0,0) beat, then 3/5.
  - `cfg_num_zeros`=12 → clamped to 8.
- **Reset mid-frame.** `resetn` low at (1,1) → all outputs 0 immediately; no `frame_done`. A `start` after release begins again at (0,0).
- **Simultaneous events.** `start` and `stop` together in IDLE → exactly one frame. `start` during RUN → no effect.
